// File: rtl/uart_byte_receiver.sv
// UART 8N1 receive deframer: two-flop rx synchroniser, mid-bit sampling,
// one-cycle valid / frame_err strobes, break hold-off after a bad stop bit.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [7:0]    shreg;

    logic at_mid;
    logic at_end;
    logic cnt_clr;
    logic sample;
    logic take_byte;
    logic bad_stop;
    logic arm_bits;

    assign at_mid = (cnt == MID);
    assign at_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (at_mid) state_nx = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (at_end && bit_idx == LAST_BIT) state_nx = STOP;
            end
            STOP: begin
                if (at_end) state_nx = rx_s ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cnt_clr   = 1'b0;
        sample    = 1'b0;
        take_byte = 1'b0;
        bad_stop  = 1'b0;
        arm_bits  = 1'b0;
        unique case (state)
            IDLE:       cnt_clr = 1'b1;
            BREAK_WAIT: cnt_clr = 1'b1;
            START: begin
                cnt_clr  = at_mid;
                arm_bits = at_mid;
            end
            DATA: begin
                cnt_clr = at_end;
                sample  = at_end;
            end
            STOP: begin
                cnt_clr   = at_end;
                take_byte = at_end && rx_s;
                bad_stop  = at_end && !rx_s;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Counters only advance inside START/DATA/STOP and clear at their
    // terminal value, so neither can wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            valid     <= take_byte;
            frame_err <= bad_stop;
            if (cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (arm_bits) begin
                bit_idx <= '0;
            end else if (sample) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (sample) begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (bit_idx == BW'(i)) shreg[i] <= rx_s;
                end
            end
            if (take_byte) begin
                data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: serial frames built from bytes,
// expected bytes queued at send time and checked by an output monitor.
`timescale 1ns/1ps
module tb_uart_byte_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int n_valid     = 0;
    int n_ferr      = 0;
    int exp_ferr    = 0;
    logic [7:0] exp_q[$];
    logic pv = 1'b0;
    logic pf = 1'b0;

    uart_byte_receiver #(
        .CLKS_PER_BIT(16),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Line-level frame: start bit, data LSB first, stop bit; bp in ns.
    task automatic send_frame(input logic [7:0] b, input bit stop,
                              input int bp);
        rx = 1'b0;
        #(bp);
        for (int i = 0; i < 8; i++) begin
            rx = (b >> i) & 8'd1;
            #(bp);
        end
        rx = stop;
        #(bp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: data %0h, required no pulse",
                             data);
                end else begin
                    check("rx_byte", data, exp_q.pop_front());
                end
                check("valid_pulse_shape", pv | frame_err, 0);
            end
            if (frame_err) begin
                n_ferr++;
                check("ferr_pulse_shape", pf | valid, 0);
            end
        end
        pv = valid;
        pf = frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   got;
        int   lat;
        int   nv;
        logic [7:0] b;
        int   bp;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // single 0xA5 frame with latency measurement
        @(posedge clk);
        #1;
        exp_q.push_back(8'hA5);
        got = 0;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 160);
            begin
                for (int n = 1; n <= 400 && !got; n++) begin
                    @(posedge clk);
                    #1;
                    if (n == 80) check("busy_mid_frame", busy, 1);
                    if (valid) begin
                        got = 1;
                        lat = n - 1;
                    end
                end
            end
        join
        check("a5_valid_seen", got, 1);
        check("a5_latency_152pm3", (lat >= 149 && lat <= 155), 1);
        repeat (20) @(posedge clk);
        #1;
        check("a5_data_held", data, 8'hA5);

        // back-to-back 0x00, 0xFF
        nv = n_valid;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 160);
        send_frame(8'hFF, 1'b1, 160);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_pulse_count", n_valid - nv, 2);
        check("b2b_low_bits", data[1:0], 2'b11);

        // 4-cycle glitch on the line
        nv = n_valid;
        @(posedge clk);
        #1;
        got = 0;
        lat = 0;
        fork
            begin
                rx = 1'b0;
                #40;
                rx = 1'b1;
            end
            begin
                for (int n = 1; n <= 40 && !got; n++) begin
                    @(posedge clk);
                    #1;
                    if (n > 3 && !busy) begin
                        got = 1;
                        lat = n - 1;
                    end
                end
            end
        join
        check("glitch_busy_dropped", got, 1);
        check("glitch_busy_within_10", lat <= 10, 1);
        repeat (30) @(posedge clk);
        #1;
        check("glitch_no_valid", n_valid - nv, 0);
        check("glitch_data_kept", data, 8'hFF);

        // bad stop bit followed by a held-low break
        nv = n_valid;
        exp_ferr++;
        send_frame(8'h3C, 1'b0, 160);
        #400;
        check("break_busy_held", busy, 1);
        check("break_data_kept", data, 8'hFF);
        check("break_ferr_once", n_ferr, exp_ferr);
        check("break_no_valid", n_valid - nv, 0);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("break_busy_released", busy, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 160);
        repeat (20) @(posedge clk);
        #1;
        check("after_break_data", data, 8'h81);

        // reset in the middle of 0x5A
        nv = n_valid;
        rx = 1'b0;
        #160;
        for (int i = 0; i < 4; i++) begin
            rx = (8'h5A >> i) & 8'd1;
            #160;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_busy", busy, 0);
        repeat (200) @(posedge clk);
        #1;
        check("midrst_no_pulse", n_valid - nv, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 160);
        repeat (20) @(posedge clk);
        #1;
        check("after_rst_data", data, 8'h5A);

        // random bytes with per-frame bit-period jitter of up to 2%
        for (int f = 0; f < 300; f++) begin
            b  = 8'($urandom);
            bp = $urandom_range(157, 163);
            exp_q.push_back(b);
            send_frame(b, 1'b1, bp);
            if ($urandom_range(0, 3) == 0) #($urandom_range(1, 200));
        end
        repeat (50) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_err_total", n_ferr, exp_ferr);
        check("valid_total", n_valid, 305);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
